// File: rtl/dcache_line_adapter.sv
// dcache_line_adapter
//   Bridges the data cache's 128-bit line request port to a 32-bit word RAM.
//   Each line fill or writeback becomes BEATS sequential word beats. Fill
//   beats are assembled into line_rdata, and completion is signalled with a
//   one-cycle line_done pulse. One line is in flight at a time, with at most
//   one word beat outstanding.
//
// Optional build macro: DCACHE_ADAPTER_CWF_EN
//   When defined, a fill starts at the critical word line_addr[3:2] and wraps
//   modulo BEATS. Writebacks always start at word 0.
//
// Ports
//   clk, RESET   clock; synchronous active-high reset
//   line_addr    byte address of the line (offset bits ignored for the base)
//   line_wdata   writeback line; word k = bits [32k+31:32k]
//   line_rw      1 = writeback, 0 = fill
//   line_valid   request valid; held by the cache until line_ready
//   line_ready   adapter idle and able to accept a request
//   line_rdata   assembled fill line
//   line_done    one-cycle completion pulse
//   mem_addr     word byte address of the current beat
//   mem_wdata    write data of the current beat
//   mem_we       current beat is a write
//   mem_valid    beat request valid
//   mem_ready    RAM accepts the beat when mem_valid && mem_ready
//   mem_rdata    RAM read data
//   mem_rvalid   mem_rdata valid (in order, latency >= 1)
module dcache_line_adapter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        line_addr,
  input  logic [WORD_W*BEATS-1:0]  line_wdata,
  input  logic                     line_rw,
  input  logic                     line_valid,
  output logic                     line_ready,
  output logic [WORD_W*BEATS-1:0]  line_rdata,
  output logic                     line_done,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [WORD_W-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  input  logic [WORD_W-1:0]        mem_rdata,
  input  logic                     mem_rvalid
);

  localparam int unsigned BW         = $clog2(BEATS);
  localparam int unsigned WORD_SH    = $clog2(WORD_W / 8);
  localparam int unsigned LINE_BYTES = WORD_W * BEATS / 8;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [BW-1:0]     LAST      = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [WORD_W*BEATS-1:0]   wdata_q, wdata_d;
  logic [WORD_W*BEATS-1:0]   rdata_q, rdata_d;
  logic                      rw_q, rw_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [BW-1:0]             cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rw_d       = rw_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    line_ready = 1'b0;
    line_done  = 1'b0;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        line_ready = 1'b1;
        if (line_valid) begin
          // Full address is kept; the line offset is masked off when forming
          // beat addresses.
          base_d  = line_addr;
          wdata_d = line_wdata;
          rw_d    = line_rw;
          cnt_d   = '0;
          beat_d  = '0;
`ifdef DCACHE_ADAPTER_CWF_EN
          if (!line_rw) beat_d = line_addr[WORD_SH +: BW];
`endif
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        mem_valid = 1'b1;
        mem_we    = rw_q;
        mem_addr  = (base_q & LINE_MASK) | (ADDR_W'(beat_q) << WORD_SH);
        mem_wdata = wdata_q[beat_q*WORD_W +: WORD_W];
        if (mem_ready) begin
          if (!rw_q) begin
            state_d = WAIT_RD;
          end else if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end

      WAIT_RD: begin
        if (mem_rvalid) begin
          rdata_d[beat_q*WORD_W +: WORD_W] = mem_rdata;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = ISSUE;
          end
        end
      end

      DONE: begin
        line_done = 1'b1;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign line_rdata = rdata_q;

endmodule
